// File: rtl/uart_tx_ctrl.sv
// UART transmitter: sends one byte per accepted tx_req as start, 8 data bits LSB-first,
// optional parity and 1 or 2 stop bits, with each bit lasting CLK_FREQ/BAUD_RATE clocks.
module uart_tx_ctrl #(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       uart_txd
);

  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(BAUD_DIV - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             PAR_ODD   = 1'(PARITY_ODD);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic             stop_idx_q;
  logic [7:0]       data_q;
  logic             par_q;
  logic             txd_q;
  logic             busy_q;
  logic             done_q;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_LAST);

  // Whole frame sequencer; the line level for the next bit is loaded on each bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      stop_idx_q <= 1'b0;
      data_q     <= '0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state_q != S_IDLE) begin
        cnt_q <= bit_end ? '0 : cnt_q + CNT_W'(1);
      end
      case (state_q)
        S_IDLE: begin
          if (tx_req) begin
            data_q     <= tx_data;
            par_q      <= (^tx_data) ^ PAR_ODD;
            busy_q     <= 1'b1;
            txd_q      <= 1'b0;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            state_q    <= S_START;
          end
        end
        S_START: begin
          if (bit_end) begin
            txd_q   <= data_q[0];
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
              if (PARITY_EN != 0) begin
                txd_q   <= par_q;
                state_q <= S_PARITY;
              end else begin
                txd_q   <= 1'b1;
                state_q <= S_STOP;
              end
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              txd_q     <= data_q[bit_idx_q + 3'd1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            txd_q   <= 1'b1;
            state_q <= S_STOP;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (stop_idx_q == STOP_LAST) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              stop_idx_q <= 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign tx_busy  = busy_q;
  assign tx_done  = done_q;
  assign uart_txd = txd_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: four instances (8N1, 8E1, 8O1, 8N2) at BAUD_DIV=10,
// line checked every cycle against hand-built frame bit patterns.
module tb_uart_tx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] data [4];
  logic [3:0] busy;
  logic [3:0] done;
  logic [3:0] txd;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  uart_tx_ctrl #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(0), .PARITY_ODD(0),
                 .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .tx_req(req[0]), .tx_data(data[0]),
    .tx_busy(busy[0]), .tx_done(done[0]), .uart_txd(txd[0]));

  uart_tx_ctrl #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1), .PARITY_ODD(0),
                 .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .tx_req(req[1]), .tx_data(data[1]),
    .tx_busy(busy[1]), .tx_done(done[1]), .uart_txd(txd[1]));

  uart_tx_ctrl #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(1), .PARITY_ODD(1),
                 .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .tx_req(req[2]), .tx_data(data[2]),
    .tx_busy(busy[2]), .tx_done(done[2]), .uart_txd(txd[2]));

  uart_tx_ctrl #(.CLK_FREQ(1_000_000), .BAUD_RATE(100_000), .PARITY_EN(0), .PARITY_ODD(0),
                 .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst_n(rst_n), .tx_req(req[3]), .tx_data(data[3]),
    .tx_busy(busy[3]), .tx_done(done[3]), .uart_txd(txd[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag, input int k);
    chk($sformatf("%s busy k%0d", tag, k), 32'(busy[k]), 32'd0);
    chk($sformatf("%s done k%0d", tag, k), 32'(done[k]), 32'd0);
    chk($sformatf("%s txd k%0d", tag, k), 32'(txd[k]), 32'd1);
  endtask

  // Entered 1 time unit after the accept edge; bits[i] is the level of line bit i.
  // Walks up to 'upto' cycles; a full walk ends on the tx_done cycle.
  task automatic check_frame(input string tag, input int k, input int nbits,
                             input logic [11:0] bits, input int upto);
    for (int c = 0; c < nbits * 10 && c < upto; c++) begin
      chk($sformatf("%s txd c%0d", tag, c), 32'(txd[k]), 32'(bits[c / 10]));
      chk($sformatf("%s busy c%0d", tag, c), 32'(busy[k]), 32'd1);
      chk($sformatf("%s done c%0d", tag, c), 32'(done[k]), 32'd0);
      @(posedge clk); #1;
    end
    if (upto >= nbits * 10) begin
      chk($sformatf("%s end busy", tag), 32'(busy[k]), 32'd0);
      chk($sformatf("%s end done", tag), 32'(done[k]), 32'd1);
      chk($sformatf("%s end txd", tag), 32'(txd[k]), 32'd1);
    end
  endtask

  task automatic send1(input string tag, input int k, input logic [7:0] d, input int nbits,
                       input logic [11:0] bits);
    @(negedge clk);
    data[k] = d;
    req[k]  = 1'b1;
    @(posedge clk); #1;
    req[k] = 1'b0;
    check_frame(tag, k, nbits, bits, 9999);
    @(posedge clk); #1;
    chk_idle({tag, " after"}, k);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req   = '0;
    for (int i = 0; i < 4; i++) data[i] = 8'h00;

    // Reset held with tx_req high: nothing may start.
    data[0] = 8'h0F;
    req[0]  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) chk_idle("reset", k);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    check_frame("t1 0x0F", 0, 10, 12'h21E, 9999);
    @(posedge clk); #1;
    chk_idle("t1 after", 0);

    send1("t2 0x55", 0, 8'h55, 10, 12'h2AA);
    send1("t3 even", 1, 8'hA3, 11, 12'h546);
    send1("t3 odd", 2, 8'hA3, 11, 12'h746);
    send1("t4 2stop", 3, 8'hFF, 11, 12'h7FE);

    // Handshake: req held until busy seen, data scrambled mid-frame.
    @(negedge clk);
    data[0] = 8'h3C;
    req[0]  = 1'b1;
    @(posedge clk); #1;
    fork
      check_frame("t5 0x3C", 0, 10, 12'h278, 9999);
      begin
        @(negedge clk);
        chk("t5 busy seen", 32'(busy[0]), 32'd1);
        req[0] = 1'b0;
        repeat (30) @(negedge clk);
        data[0] = 8'hC3;
        repeat (20) @(negedge clk);
        data[0] = 8'hFF;
      end
    join
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk_idle($sformatf("t5 quiet %0d", i), 0);
    end

    // Continuous request: three frames separated by single idle cycles.
    @(negedge clk);
    data[0] = 8'h00;
    req[0]  = 1'b1;
    @(posedge clk); #1;
    check_frame("t6 f1", 0, 10, 12'h200, 9999);
    @(posedge clk); #1;
    check_frame("t6 f2", 0, 10, 12'h200, 9999);
    @(posedge clk); #1;
    check_frame("t6 f3", 0, 10, 12'h200, 9999);
    req[0] = 1'b0;
    @(posedge clk); #1;
    chk_idle("t6 stop", 0);

    // Repeat, then reset in the middle of frame 2 data bit 4.
    @(negedge clk);
    req[0] = 1'b1;
    @(posedge clk); #1;
    check_frame("t6 r1", 0, 10, 12'h200, 9999);
    @(posedge clk); #1;
    check_frame("t6 r2", 0, 10, 12'h200, 55);
    rst_n = 1'b0;
    #1;
    chk_idle("t6 rst now", 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk_idle($sformatf("t6 rst hold %0d", i), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    req[0] = 1'b0;
    check_frame("t6 clean", 0, 10, 12'h200, 9999);
    @(posedge clk); #1;
    chk_idle("t6 final", 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
